// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX   = 4'd9;
  localparam digit_t ADD3_THRESH = 4'd5;

  function automatic digit_t add3(input digit_t d);
    return (d >= ADD3_THRESH) ? digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_seq_conv_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_seq_conv_add3
  import bcd_pkg::*;
(
  input  digit_t d_i,
  output digit_t d_o
);

  assign d_o = add3(d_i);

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per cycle.
// Define BCD_SAT_EN to saturate bcd_o to all nines when the operand overflows.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int unsigned N      = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N-1:0]          bin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(N);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]        sr_q, sr_d;
  logic [BcdW-1:0]     acc_q, acc_d;
  logic                sticky_q, sticky_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [BcdW-1:0]     acc_adj;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_seq_conv_add3 u_add3 (
      .d_i (acc_q[4*i +: 4]),
      .d_o (acc_adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d  = StShift;
          sr_d     = bin_i;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      end
      StShift: begin
        if (cnt_q == CntMax) begin
          state_d = StDone;
          ovf_d   = sticky_q;
`ifdef BCD_SAT_EN
          bcd_d   = sticky_q ? {DIGITS{DIGIT_MAX}} : acc_q;
`else
          bcd_d   = acc_q;
`endif
        end else begin
          // The carry out of the top digit is the part of the operand that does not fit.
          acc_d    = {acc_adj[BcdW-2:0], sr_q[N-1]};
          sr_d     = {sr_q[N-2:0], 1'b0};
          sticky_d = sticky_q | acc_adj[BcdW-1];
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sr_q     <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign bcd_o       = bcd_q;
  assign ovf_o       = ovf_q;

endmodule
